regfile_stage: RTL and testbench
================================

REGFILE_STAGE -- requirements
Module: regfile_stage

Interface
REQ-001 The module SHALL have parameter NREGS, default 32, meaning the number of architectural integer registers (x0..x31).
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state SHALL be updated on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit, an asynchronous active-low reset.
REQ-004 The module SHALL have port idrf_axis_if, axis_if.s, $bits(idrf_tdata_t), carrying decoded instructions from the decoder.
REQ-005 The module SHALL have port rfex_axis_if, axis_if.m, $bits(rfex_tdata_t), carrying operand-read instructions to the execute stage.
REQ-006 The module SHALL have port wb_axis_if, axis_if.s, $bits(wb_tdata_t), carrying register writebacks {rd[4:0], data[31:0]}.
REQ-007 The module SHALL have port invalidate, input, 1 bit, a pipeline flush request.

Function
REQ-008 The module SHALL hold a 32x32-bit register array in which x0 always reads as 0 and writes to x0 are discarded.
REQ-009 The module SHALL drive wb_axis_if.tready constantly to 1, and each wb beat with rd!=0 SHALL write data to reg[rd] at that edge.
REQ-010 The module SHALL hold a 32-bit pending scoreboard, with bit[rd] set when an instruction with rd!=0 is accepted and cleared when a writeback to rd is accepted.
REQ-011 The module SHALL detect a hazard when the input is valid and any of rs1, rs2 or rd (each nonzero) has its pending bit set and is not being cleared this cycle by wb.
REQ-012 The module SHALL drive idrf_axis_if.tready = (!out_valid || rfex_axis_if.tready) && !hazard && !invalidate.
REQ-013 The module SHALL accept an input beat on idrf tvalid && tready and, one cycle later, present it on rfex with tvalid=1 (latency 1).
REQ-014 The module SHALL form rfex tdata as all idrf_tdata_t fields plus rs1_data and rs2_data read at accept time.
REQ-015 The module SHALL perform a same-cycle write-before-read bypass, so that a wb to rs1 or rs2 in the accept cycle supplies the written data.
REQ-016 The module SHALL hold rfex tdata and tvalid stable while tvalid && !tready.
REQ-017 The module SHALL give set priority over clear when, in one cycle, an accept sets bit r and a wb clears bit r.
REQ-018 On invalidate, the module SHALL at the next edge clear out_valid, accept no input that cycle, and clear the pending bit of the rd held in the output register if that entry was not handed off.
REQ-019 The module SHALL let invalidate leave the register array and all other pending bits unchanged, since older instructions still write back.
REQ-020 A wb to a register whose pending bit is clear SHALL still update the array without error.

Reset
REQ-021 On reset, the module SHALL drive rfex tvalid=0, clear every pending bit, clear every register to 0 and drive idrf tready=0.
REQ-022 A reset asserted mid-transfer SHALL drop the in-flight beat with no partial state retained, and the module SHALL resume operation at the first clock edge after deassertion.

Structure
REQ-023 The typedefs rfex_tdata_t (idrf_tdata_t plus rs1_data and rs2_data) and wb_tdata_t SHALL reside in offnariscv_pkg.
REQ-024 The module SHALL instantiate one sub-module, regfile_array (32x32 storage, 2 read ports, 1 write port, x0 hardwired), and keep the scoreboard and output register in regfile_stage.

Verification
REQ-025 The bench SHALL write reg[5]=0x1234 via wb, then issue rs1=5, rs2=0, and check rfex rs1_data=0x1234, rs2_data=0 one cycle after accept.
REQ-026 The bench SHALL issue rd=7, then an instruction with rs1=7, and check that tready stays 0 until wb rd=7 data=0xA5A5A5A5, after which the second beat is accepted in that cycle with rs1_data=0xA5A5A5A5.
REQ-027 The bench SHALL hold rfex tready=0 for 5 cycles and check that rfex tdata and tvalid stay constant and that idrf tready=0 throughout.
REQ-028 The bench SHALL issue rd=3 held in the output register, assert invalidate, and check that rfex tvalid=0 next cycle, pending[3]=0, and that a following rs1=3 is accepted without stall.
REQ-029 The bench SHALL issue wb rd=0 data=0xFFFFFFFF followed by a read of rs1=0, and check rs1_data=0.
REQ-030 The bench SHALL apply reset during a stalled transfer and check that all outputs return to reset values and the pending scoreboard reads all-zero.

Source files
------------

// File: rtl/offnariscv_pkg.sv
// Shared pipeline payload types for the decode -> regfile -> execute path
// and the writeback bus.
package offnariscv_pkg;
  localparam int XLEN = 32;
  localparam int RAW  = 5;

  typedef logic [RAW-1:0] reg_idx_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [3:0]      funct;
    reg_idx_t        rd;
    reg_idx_t        rs1;
    reg_idx_t        rs2;
  } idrf_tdata_t;

  typedef struct packed {
    idrf_tdata_t     instr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
  } rfex_tdata_t;

  typedef struct packed {
    reg_idx_t        rd;
    logic [XLEN-1:0] data;
  } wb_tdata_t;
endpackage

// File: rtl/axis_if.sv
// Minimal valid/ready stream bundle; m drives payload, s drives tready.
interface axis_if #(
  parameter int DATA_W = 8
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;

  modport m (output tvalid, output tdata, input tready);
  modport s (input tvalid, input tdata, output tready);
endinterface

// File: rtl/regfile_array.sv
// Integer register storage: 2 async read ports with write-before-read
// bypass, 1 write port, x0 hardwired to zero.
module regfile_array
  import offnariscv_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  reg_idx_t        waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  reg_idx_t        raddr1_i,
  input  reg_idx_t        raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o
);
  logic [NREGS-1:0][XLEN-1:0] mem_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '0;
    end else if (we_i && waddr_i != '0) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == '0)                 ? '0      :
                    (we_i && waddr_i == raddr1_i)    ? wdata_i : mem_q[raddr1_i];
  assign rdata2_o = (raddr2_i == '0)                 ? '0      :
                    (we_i && waddr_i == raddr2_i)    ? wdata_i : mem_q[raddr2_i];
endmodule

// File: rtl/regfile_stage.sv
// Register-read pipeline stage: operand fetch, pending-write scoreboard
// for RAW/WAW stalls, and a single output register toward execute.
module regfile_stage
  import offnariscv_pkg::*;
#(
  parameter int NREGS = 32
) (
  input logic clk,
  input logic rst,
  axis_if.s   idrf_axis_if,
  axis_if.m   rfex_axis_if,
  axis_if.s   wb_axis_if,
  input logic invalidate
);
  idrf_tdata_t      in_s;
  wb_tdata_t        wb_s;
  logic             wb_we;
  logic             hazard;
  logic             accept;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic [NREGS-1:0] pend_q, pend_d;
  logic [NREGS-1:0] wb_clr;
  logic [NREGS-1:0] busy;
  logic             out_valid_q, out_valid_d;
  rfex_tdata_t      out_q, out_d;

  assign in_s = idrf_axis_if.tdata;
  assign wb_s = wb_axis_if.tdata;

  assign wb_axis_if.tready = 1'b1;
  assign wb_we             = wb_axis_if.tvalid && (wb_s.rd != '0);

  regfile_array #(.NREGS(NREGS)) u_array (
    .clk      (clk),
    .rst      (rst),
    .we_i     (wb_we),
    .waddr_i  (wb_s.rd),
    .wdata_i  (wb_s.data),
    .raddr1_i (in_s.rs1),
    .raddr2_i (in_s.rs2),
    .rdata1_o (rs1_data),
    .rdata2_o (rs2_data)
  );

  // A writeback landing this cycle releases its register immediately.
  // Bit 0 is never set, so x0 operands/destinations never stall.
  assign wb_clr = wb_we ? (NREGS'(1) << wb_s.rd) : '0;
  assign busy   = pend_q & ~wb_clr;
  assign hazard = idrf_axis_if.tvalid &&
                  (busy[in_s.rs1] || busy[in_s.rs2] || busy[in_s.rd]);

  assign idrf_axis_if.tready = rst && (!out_valid_q || rfex_axis_if.tready) &&
                               !hazard && !invalidate;
  assign accept = idrf_axis_if.tvalid && idrf_axis_if.tready;

  always_comb begin
    pend_d = busy;
    // A flushed entry that never reached execute will never write back.
    if (invalidate && out_valid_q && !rfex_axis_if.tready)
      pend_d = pend_d & ~(NREGS'(1) << out_q.instr.rd);
    if (accept && in_s.rd != '0)
      pend_d[in_s.rd] = 1'b1;

    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (invalidate) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d    = 1'b1;
      out_d.instr    = in_s;
      out_d.rs1_data = rs1_data;
      out_d.rs2_data = rs2_data;
    end else if (rfex_axis_if.tready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q      <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign rfex_axis_if.tvalid = out_valid_q;
  assign rfex_axis_if.tdata  = out_q;
endmodule

// File: tb/tb_regfile_stage.sv
// Bench for regfile_stage: vector table, directed corner sequences and a
// randomized run against a queue/array reference model.
module tb_regfile_stage;
  import offnariscv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic invalidate = 1'b0;
  always #5 clk = ~clk;

  axis_if #(.DATA_W($bits(idrf_tdata_t))) idrf ();
  axis_if #(.DATA_W($bits(rfex_tdata_t))) rfex ();
  axis_if #(.DATA_W($bits(wb_tdata_t)))   wb ();

  regfile_stage #(.NREGS(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .idrf_axis_if (idrf),
    .rfex_axis_if (rfex),
    .wb_axis_if   (wb),
    .invalidate   (invalidate)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] m_regs [32];
  bit   [31:0] m_pend;
  rfex_tdata_t exp_q [$];

  typedef struct {
    bit          same;
    logic [4:0]  wrd;
    logic [31:0] wdat;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;
  vec_t vt [7];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
  endtask

  function automatic idrf_tdata_t mk(input logic [31:0] pc, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    idrf_tdata_t t;
    t.pc = pc; t.imm = ~pc; t.funct = pc[3:0];
    t.rd = rd; t.rs1 = rs1; t.rs2 = rs2;
    return t;
  endfunction

  function automatic rfex_tdata_t ex(input idrf_tdata_t i, input logic [31:0] a,
                                     input logic [31:0] b);
    rfex_tdata_t r;
    r.instr = i; r.rs1_data = a; r.rs2_data = b;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input idrf_tdata_t t, input string nm);
    idrf.tvalid = 1'b1;
    idrf.tdata  = t;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (idrf.tready) begin
        step();
        idrf.tvalid = 1'b0;
        return;
      end
      step();
    end
    chk({nm, " accept timeout"}, 256'(0), 256'(1));
    idrf.tvalid = 1'b0;
  endtask

  // Model helpers: a register is blocked if pending and not written back now.
  function automatic bit blocked(input logic [4:0] r, input bit wf, input logic [4:0] wr);
    return (r != 0) && m_pend[r] && !(wf && wr == r);
  endfunction

  function automatic logic [31:0] rv(input logic [4:0] r, input bit wf, input wb_tdata_t w);
    if (r == 0) return 32'h0;
    if (wf && w.rd == r) return w.data;
    return m_regs[r];
  endfunction

  initial begin
    #200000;
    $display("FAIL global timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idrf_tdata_t t, a, b, c, d, e, f, g, h, k, in;
    wb_tdata_t   w;
    bit          wf, hz, rdy, acc, full;

    vt[0] = '{1'b0, 5'd5,  32'h0000_1234, 5'd5,  5'd0,  32'h0000_1234, 32'h0};
    vt[1] = '{1'b0, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd0,  32'h0,         32'h0};
    vt[2] = '{1'b0, 5'd9,  32'hDEAD_BEEF, 5'd9,  5'd5,  32'hDEAD_BEEF, 32'h0000_1234};
    vt[3] = '{1'b1, 5'd10, 32'hCAFE_F00D, 5'd10, 5'd9,  32'hCAFE_F00D, 32'hDEAD_BEEF};
    vt[4] = '{1'b1, 5'd5,  32'h0000_5555, 5'd5,  5'd5,  32'h0000_5555, 32'h0000_5555};
    vt[5] = '{1'b0, 5'd31, 32'h8000_0001, 5'd0,  5'd31, 32'h0,         32'h8000_0001};
    vt[6] = '{1'b1, 5'd0,  32'h0000_0077, 5'd0,  5'd0,  32'h0,         32'h0};

    idrf.tvalid = 1'b0; idrf.tdata = '0;
    wb.tvalid   = 1'b0; wb.tdata   = '0;
    rfex.tready = 1'b1;

    #3;
    chk("reset rfex tvalid", 256'(rfex.tvalid), 256'(0));
    chk("reset idrf tready", 256'(idrf.tready), 256'(0));
    chk("reset pending", 256'(dut.pend_q), 256'(0));
    chk("wb tready", 256'(wb.tready), 256'(1));
    @(negedge clk);
    rst = 1'b1;
    step();

    // Vector table: writeback (separate or same cycle) then operand read.
    for (int i = 0; i < 7; i++) begin
      t = mk(32'h100 + 32'(i), 5'd0, vt[i].rs1, vt[i].rs2);
      wb.tvalid = 1'b1;
      wb.tdata  = {vt[i].wrd, vt[i].wdat};
      if (!vt[i].same) begin
        step();
        wb.tvalid = 1'b0;
      end
      issue(t, $sformatf("tbl%0d", i));
      wb.tvalid = 1'b0;
      chk($sformatf("tbl%0d tvalid", i), 256'(rfex.tvalid), 256'(1));
      chk($sformatf("tbl%0d tdata", i), 256'(rfex.tdata), 256'(ex(t, vt[i].e1, vt[i].e2)));
    end

    // RAW stall on x7 released by a writeback in the accept cycle.
    a = mk(32'h200, 5'd7, 5'd0, 5'd0);
    issue(a, "raw A");
    chk("raw A tdata", 256'(rfex.tdata), 256'(ex(a, 32'h0, 32'h0)));
    b = mk(32'h204, 5'd0, 5'd7, 5'd0);
    idrf.tvalid = 1'b1; idrf.tdata = b;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("raw stall tready", 256'(idrf.tready), 256'(0));
      step();
    end
    wb.tvalid = 1'b1; wb.tdata = {5'd7, 32'hA5A5_A5A5};
    @(negedge clk);
    chk("raw release tready", 256'(idrf.tready), 256'(1));
    step();
    wb.tvalid = 1'b0; idrf.tvalid = 1'b0;
    chk("raw B tvalid", 256'(rfex.tvalid), 256'(1));
    chk("raw B tdata", 256'(rfex.tdata), 256'(ex(b, 32'hA5A5_A5A5, 32'h0)));

    // Downstream backpressure: output held stable, input blocked.
    step();
    rfex.tready = 1'b0;
    c = mk(32'h300, 5'd0, 5'd9, 5'd31);
    issue(c, "hold");
    d = mk(32'h304, 5'd0, 5'd10, 5'd0);
    idrf.tvalid = 1'b1; idrf.tdata = d;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold tvalid", 256'(rfex.tvalid), 256'(1));
      chk("hold tdata", 256'(rfex.tdata), 256'(ex(c, 32'hDEAD_BEEF, 32'h8000_0001)));
      chk("hold idrf tready", 256'(idrf.tready), 256'(0));
      step();
    end
    rfex.tready = 1'b1;
    @(negedge clk);
    chk("hold release tready", 256'(idrf.tready), 256'(1));
    step();
    idrf.tvalid = 1'b0;
    chk("hold next tdata", 256'(rfex.tdata), 256'(ex(d, 32'hCAFE_F00D, 32'h0)));

    // Flush of an un-handed-off rd=3 entry releases its pending bit.
    step();
    rfex.tready = 1'b0;
    e = mk(32'h400, 5'd3, 5'd0, 5'd0);
    issue(e, "inv");
    chk("inv pend set", 256'(dut.pend_q[3]), 256'(1));
    f = mk(32'h404, 5'd0, 5'd3, 5'd0);
    idrf.tvalid = 1'b1; idrf.tdata = f;
    invalidate = 1'b1;
    @(negedge clk);
    chk("inv idrf tready", 256'(idrf.tready), 256'(0));
    step();
    invalidate = 1'b0;
    chk("inv rfex tvalid", 256'(rfex.tvalid), 256'(0));
    chk("inv pend clear", 256'(dut.pend_q[3]), 256'(0));
    @(negedge clk);
    chk("inv no stall", 256'(idrf.tready), 256'(1));
    step();
    idrf.tvalid = 1'b0;
    chk("inv next tdata", 256'(rfex.tdata), 256'(ex(f, 32'h0, 32'h0)));
    rfex.tready = 1'b1;
    step();

    // Reset in the middle of a stalled transfer.
    rfex.tready = 1'b0;
    g = mk(32'h500, 5'd12, 5'd0, 5'd0);
    issue(g, "rst");
    h = mk(32'h504, 5'd0, 5'd12, 5'd0);
    idrf.tvalid = 1'b1; idrf.tdata = h;
    @(negedge clk);
    chk("rst stalled tready", 256'(idrf.tready), 256'(0));
    #2 rst = 1'b0;
    #1;
    chk("rst mid tvalid", 256'(rfex.tvalid), 256'(0));
    chk("rst mid tdata", 256'(rfex.tdata), 256'(0));
    chk("rst mid idrf tready", 256'(idrf.tready), 256'(0));
    chk("rst mid pending", 256'(dut.pend_q), 256'(0));
    idrf.tvalid = 1'b0; rfex.tready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    k = mk(32'h600, 5'd0, 5'd5, 5'd9);
    idrf.tvalid = 1'b1; idrf.tdata = k;
    #1;
    chk("post-rst tready", 256'(idrf.tready), 256'(1));
    step();
    idrf.tvalid = 1'b0;
    chk("post-rst tvalid", 256'(rfex.tvalid), 256'(1));
    chk("post-rst tdata", 256'(rfex.tdata), 256'(ex(k, 32'h0, 32'h0)));

    // Randomized run from the clean post-reset state.
    foreach (m_regs[i]) m_regs[i] = 32'h0;
    m_pend = '0;
    exp_q.delete();
    exp_q.push_back(ex(k, 32'h0, 32'h0));
    for (int cyc = 0; cyc < 400; cyc++) begin
      idrf.tvalid = ($urandom % 3) != 0;
      idrf.tdata  = mk($urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)));
      wb.tvalid   = ($urandom % 3) == 0;
      wb.tdata    = {5'($urandom_range(0, 7)), 32'($urandom)};
      rfex.tready = ($urandom % 4) != 0;
      invalidate  = ($urandom % 16) == 0;
      @(negedge clk);
      in   = idrf.tdata;
      w    = wb.tdata;
      wf   = wb.tvalid;
      full = exp_q.size() != 0;
      hz   = idrf.tvalid && (blocked(in.rs1, wf, w.rd) || blocked(in.rs2, wf, w.rd) ||
                             blocked(in.rd, wf, w.rd));
      rdy  = (!full || rfex.tready) && !hz && !invalidate;
      acc  = idrf.tvalid && rdy;
      chk("rnd idrf tready", 256'(idrf.tready), 256'(rdy));
      t = in;
      if (acc) exp_q.push_back(ex(t, rv(in.rs1, wf, w), rv(in.rs2, wf, w)));
      if (full && rfex.tready) void'(exp_q.pop_front());
      else if (full && invalidate && exp_q[0].instr.rd != 0) m_pend[exp_q[0].instr.rd] = 1'b0;
      if (invalidate) exp_q.delete();
      if (wf && w.rd != 0) begin
        m_regs[w.rd] = w.data;
        m_pend[w.rd] = 1'b0;
      end
      if (acc && in.rd != 0) m_pend[in.rd] = 1'b1;
      step();
      chk("rnd rfex tvalid", 256'(rfex.tvalid), 256'(exp_q.size() != 0));
      if (exp_q.size() != 0)
        chk("rnd rfex tdata", 256'(rfex.tdata), 256'(exp_q[0]));
    end
    chk("rnd final pending", 256'(dut.pend_q), 256'(m_pend));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
